// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 receiver and ZX Spectrum 40-key matrix responder.
// Define PS2_EXTENDED_KEYS_EN to decode E0-prefixed cursor/enter/ctrl keys.
module ps2_keyboard_matrix #(
   parameter int TIMEOUT_CYCLES = 14000
) (
   input  logic       clk14,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       ps2data,
   input  logic [7:0] rows,
   output logic [4:0] columns,
   output logic [7:0] scancode,
   output logic       scan_strobe
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE, S_DATA, S_PARITY, S_STOP
   } state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic [3:0]    clk_hist;
   logic          clk_filt, fall, din;
   state_t        state, state_n;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          par_bit, timeout, byte_good;
   logic [TW-1:0] tcnt;
   logic [39:0]   phys, eff;
   logic          brk, ext, bksp;
   logic          c_brk, c_ext, c_ign, c_clr;
   logic [6:0]    map;
`ifdef PS2_EXTENDED_KEYS_EN
   logic [5:0]    xk;
`endif

   // Map a set-2 code to {valid, k*5+j}.
   function automatic logic [6:0] key_map(input logic [7:0] c);
      unique case (c)
         8'h12, 8'h59: key_map = {1'b1, 6'd0};
         8'h1A: key_map = {1'b1, 6'd1};
         8'h22: key_map = {1'b1, 6'd2};
         8'h21: key_map = {1'b1, 6'd3};
         8'h2A: key_map = {1'b1, 6'd4};
         8'h1C: key_map = {1'b1, 6'd5};
         8'h1B: key_map = {1'b1, 6'd6};
         8'h23: key_map = {1'b1, 6'd7};
         8'h2B: key_map = {1'b1, 6'd8};
         8'h34: key_map = {1'b1, 6'd9};
         8'h15: key_map = {1'b1, 6'd10};
         8'h1D: key_map = {1'b1, 6'd11};
         8'h24: key_map = {1'b1, 6'd12};
         8'h2D: key_map = {1'b1, 6'd13};
         8'h2C: key_map = {1'b1, 6'd14};
         8'h16: key_map = {1'b1, 6'd15};
         8'h1E: key_map = {1'b1, 6'd16};
         8'h26: key_map = {1'b1, 6'd17};
         8'h25: key_map = {1'b1, 6'd18};
         8'h2E: key_map = {1'b1, 6'd19};
         8'h45: key_map = {1'b1, 6'd20};
         8'h46: key_map = {1'b1, 6'd21};
         8'h3E: key_map = {1'b1, 6'd22};
         8'h3D: key_map = {1'b1, 6'd23};
         8'h36: key_map = {1'b1, 6'd24};
         8'h4D: key_map = {1'b1, 6'd25};
         8'h44: key_map = {1'b1, 6'd26};
         8'h43: key_map = {1'b1, 6'd27};
         8'h3C: key_map = {1'b1, 6'd28};
         8'h35: key_map = {1'b1, 6'd29};
         8'h5A: key_map = {1'b1, 6'd30};
         8'h4B: key_map = {1'b1, 6'd31};
         8'h42: key_map = {1'b1, 6'd32};
         8'h3B: key_map = {1'b1, 6'd33};
         8'h33: key_map = {1'b1, 6'd34};
         8'h29: key_map = {1'b1, 6'd35};
         8'h14: key_map = {1'b1, 6'd36};
         8'h3A: key_map = {1'b1, 6'd37};
         8'h31: key_map = {1'b1, 6'd38};
         8'h32: key_map = {1'b1, 6'd39};
         default: key_map = 7'd0;
      endcase
   endfunction

   // Two-flop synchronizers for both raw PS/2 lines.
   always_ff @(posedge clk14) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2clk};
         dat_sync <= {dat_sync[0], ps2data};
      end
   end

   // Glitch filter: level follows four equal samples.
   always_ff @(posedge clk14) begin
      if (reset) begin
         clk_hist <= 4'hF;
         clk_filt <= 1'b1;
      end else begin
         clk_hist <= {clk_hist[2:0], clk_sync[1]};
         if (clk_hist == 4'h0)
            clk_filt <= 1'b0;
         else if (clk_hist == 4'hF)
            clk_filt <= 1'b1;
      end
   end

   assign fall    = clk_filt && (clk_hist == 4'h0);
   assign din     = dat_sync[1];
   assign timeout = (state != S_IDLE) &&
                    (tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Receive FSM state register.
   always_ff @(posedge clk14) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next state; a falling edge takes priority over timeout.
   always_comb begin
      state_n = state;
      if (fall) begin
         unique case (state)
            S_IDLE:   if (!din) state_n = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
            S_PARITY: state_n = S_STOP;
            S_STOP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
         endcase
      end else if (timeout) begin
         state_n = S_IDLE;
      end
   end

   // Frame accepted on a good stop bit with odd parity.
   always_comb begin
      byte_good = fall && (state == S_STOP) && din &&
                  (^{par_bit, shreg});
   end

   // Shift register, bit counter and inactivity timer.
   always_ff @(posedge clk14) begin
      if (reset) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
         par_bit <= 1'b0;
         tcnt    <= '0;
      end else begin
         if (fall || state_n == S_IDLE) tcnt <= '0;
         else                           tcnt <= tcnt + 1'b1;
         if (fall) begin
            unique case (state)
               S_IDLE: bit_cnt <= 3'd0;
               S_DATA: begin
                  shreg   <= {din, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               S_PARITY: par_bit <= din;
               default: ;
            endcase
         end
      end
   end

   assign map   = key_map(shreg);
   assign c_brk = (shreg == 8'hF0);
   assign c_ext = (shreg == 8'hE0);
   assign c_clr = (shreg == 8'h00) || (shreg == 8'hFF);
   assign c_ign = !brk && !ext &&
                  ((shreg == 8'hFA) || (shreg == 8'hAA) ||
                   (shreg == 8'hEE) || (shreg == 8'hFE));

   // Scan code decoder and matrix image update.
   always_ff @(posedge clk14) begin
      if (reset) begin
         phys        <= '0;
         bksp        <= 1'b0;
         brk         <= 1'b0;
         ext         <= 1'b0;
         scancode    <= 8'h00;
         scan_strobe <= 1'b0;
`ifdef PS2_EXTENDED_KEYS_EN
         xk          <= '0;
`endif
      end else begin
         scan_strobe <= byte_good;
         if (byte_good) begin
            scancode <= shreg;
            unique case (1'b1)
               c_brk: brk <= 1'b1;
               c_ext: ext <= 1'b1;
               c_ign: ;
               c_clr: begin
                  phys <= '0;
                  bksp <= 1'b0;
                  brk  <= 1'b0;
                  ext  <= 1'b0;
`ifdef PS2_EXTENDED_KEYS_EN
                  xk   <= '0;
`endif
               end
               default: begin
                  brk <= 1'b0;
                  ext <= 1'b0;
                  if (!ext) begin
                     if (shreg == 8'h66) bksp <= !brk;
                     else if (map[6])    phys[map[5:0]] <= !brk;
                  end
`ifdef PS2_EXTENDED_KEYS_EN
                  else begin
                     unique case (shreg)
                        8'h6B: xk[0] <= !brk;
                        8'h72: xk[1] <= !brk;
                        8'h75: xk[2] <= !brk;
                        8'h74: xk[3] <= !brk;
                        8'h5A: xk[4] <= !brk;
                        8'h14: xk[5] <= !brk;
                        default: ;
                     endcase
                  end
`endif
               end
            endcase
         end
      end
   end

   // Physical image ORed with composite key contributions.
   always_comb begin
      eff = phys;
      if (bksp) begin
         eff[0]  = 1'b1;
         eff[20] = 1'b1;
      end
`ifdef PS2_EXTENDED_KEYS_EN
      if (|xk[3:0]) eff[0] = 1'b1;
      if (xk[0]) eff[19] = 1'b1;
      if (xk[1]) eff[24] = 1'b1;
      if (xk[2]) eff[23] = 1'b1;
      if (xk[3]) eff[22] = 1'b1;
      if (xk[4]) eff[30] = 1'b1;
      if (xk[5]) eff[36] = 1'b1;
`endif
   end

   // Column answer to the ULA half-row scan.
   always_comb begin
      columns = 5'b11111;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 5; j++)
            if (!rows[k] && eff[k*5+j]) columns[j] = 1'b0;
   end

endmodule
